nfu_2_accumulate: RTL and testbench
===================================

NFU_2_ACCUMULATE -- requirements
Module: nfu_2_accumulate

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning width of one fixed-point value (two's complement).
REQ-002 SHALL have parameter Q, default 10, meaning number of fractional bits.
REQ-003 SHALL have parameter Tn, default 16, meaning number of output neurons, and also synapse products per neuron per beat (power of two).
REQ-004 SHALL have port clk, input, 1 bit: the one clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, 1 bit: the beat on i_nfu1_out is valid.
REQ-007 SHALL have port i_first, input, 1 bit: the beat opens a new accumulation group; qualified by i_valid.
REQ-008 SHALL have port i_last, input, 1 bit: the beat closes the group, so the result is emitted; qualified by i_valid.
REQ-009 SHALL have port i_psum_en, input, 1 bit: with i_first, seed the accumulator from i_psum instead of 0.
REQ-010 SHALL have port i_psum, input, Tn*BIT_WIDTH: per-neuron seed partial sums.
REQ-011 SHALL have port i_nfu1_out, input, Tn*Tn*BIT_WIDTH: product for neuron n, synapse s, at slice index n*Tn+s.
REQ-012 SHALL have port o_valid, output, 1 bit: one-cycle pulse; o_nfu2_out holds a completed group.
REQ-013 SHALL have port o_nfu2_out, output, Tn*BIT_WIDTH: per-neuron sums for the downstream sigmoid stage, neuron n at slice n.
REQ-014 SHALL have port o_seq_err, output, 1 bit: one-cycle pulse on a protocol violation.

Function
REQ-015 SHALL reduce the Tn products of each neuron with a binary adder tree of LOG2_TN = log2(Tn) levels, registered after every level.
REQ-016 SHALL use a saturating two's-complement adder at every tree node and at the accumulator: clamp to 0x7FFF/0x8000 (for BIT_WIDTH=16).
REQ-017 SHALL pipeline first/last/psum_en/psum sidebands alongside the data so each reaches the accumulator stage with its own beat.
REQ-018 SHALL, at the accumulator stage, load seed+tree_sum when the beat has first set (seed = i_psum if psum_en else 0), and otherwise load acc+tree_sum.
REQ-019 SHALL assert o_valid exactly LOG2_TN+1 cycles after the i_valid beat carrying i_last (5 cycles at Tn=16), with o_nfu2_out = the post-add accumulator.
REQ-020 SHALL hold o_nfu2_out stable until the next o_valid; there is no backpressure.
REQ-021 SHALL leave the accumulator and state unchanged on a cycle where i_valid=0 (bubble); gaps inside a group are legal.
REQ-022 SHALL implement a 2-state FSM at the accumulator stage: IDLE to ACCUM on a first-without-last beat; ACCUM to IDLE on a last beat; first+last in the same beat is a single-beat group and stays in/returns to IDLE.
REQ-023 SHALL, for a beat in IDLE without first: pulse o_seq_err and treat the beat as first with seed 0.
REQ-024 SHALL, for a beat in ACCUM with first: pulse o_seq_err, discard the old accumulation, and start a new group (REQ-018).
REQ-025 SHALL support back-to-back groups (last then first on consecutive cycles) at full throughput, one beat per cycle.

Reset
REQ-026 SHALL, on rst: clear all pipeline valid flags, accumulator, o_nfu2_out, o_valid and o_seq_err to 0, and set the FSM to IDLE.
REQ-027 SHALL drop beats in flight during rst; no o_valid follows them.
REQ-028 SHALL not require data-path registers other than the accumulator and outputs to be reset.

Structure
REQ-029 SHALL take BIT_WIDTH, Q, Tn, LOG2_TN, the FSM state encoding and the saturating-add function from a shared package nfu_pkg, also used by nfu_1 and nfu_3.
REQ-030 SHALL instantiate sub-module nfu2_adder_tree (Tn inputs, registered levels, one sum) Tn times via generate; the accumulator and FSM stay in the top module.

Verification
REQ-031 SHALL verify: one beat, first=last=1, all products 0x0040 → o_valid 5 cycles later, every lane 0x0400 (1.0).
REQ-032 SHALL verify: 3 beats of 0x0040 with a 1-cycle bubble after beat 1, first on beat 1 and last on beat 3 → one o_valid, lanes 0x0C00, o_seq_err never set.
REQ-033 SHALL verify saturation: all products 0x7000 → lanes 0x7FFF; all products 0x8000 → lanes 0x8000.
REQ-034 SHALL verify: psum_en=1, i_psum lanes 0xFC00 (-1.0), products 0x0040, first=last=1 → lanes 0x0000.
REQ-035 SHALL verify: first beat, rst pulsed 2 cycles later, then a new single beat of 0x0080 → exactly one o_valid, lanes 0x0800.
REQ-036 SHALL verify: a beat without first while IDLE → o_seq_err pulse, and the group still sums correctly from seed 0.

Source files
------------

// File: rtl/nfu_pkg.sv
// Shared definitions for the NFU pipeline stages: default geometry, the
// accumulator FSM encoding and the saturating adder used by every stage.
package nfu_pkg;

   localparam int BIT_WIDTH = 16;
   localparam int Q         = 10;
   localparam int Tn        = 16;
   localparam int LOG2_TN   = $clog2(Tn);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } acc_state_e;

   // Operands arrive sign-extended to 64 bits; the result is clamped to a
   // w-bit two's-complement range and the caller truncates to w bits.
   function automatic logic [63:0] sat_add(input logic signed [63:0] a,
                                           input logic signed [63:0] b,
                                           input int w);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi) begin
         return hi;
      end else if (s < lo) begin
         return lo;
      end
      return s;
   endfunction

endpackage

// File: rtl/nfu2_adder_tree.sv
// Pipelined binary reduction of Tn fixed-point values; every level is
// registered, so the sum appears log2(Tn) cycles after the inputs.
module nfu2_adder_tree #(
   parameter int BIT_WIDTH = nfu_pkg::BIT_WIDTH,
   parameter int Tn        = nfu_pkg::Tn
) (
   input  logic                      clk,
   input  logic [Tn*BIT_WIDTH-1:0]   i_data,
   output logic [BIT_WIDTH-1:0]      o_sum
);
   import nfu_pkg::*;

   localparam int LVLS = $clog2(Tn);

   genvar gi, gj;
   generate
      for (gi = 0; gi < LVLS; gi++) begin : g_lvl
         for (gj = 0; gj < (Tn >> (gi + 1)); gj++) begin : g_node
            logic [BIT_WIDTH-1:0] w_a;
            logic [BIT_WIDTH-1:0] w_b;
            logic [BIT_WIDTH-1:0] r_sum;
            if (gi == 0) begin : g_leaf
               assign w_a = i_data[(2*gj)*BIT_WIDTH +: BIT_WIDTH];
               assign w_b = i_data[(2*gj+1)*BIT_WIDTH +: BIT_WIDTH];
            end else begin : g_inner
               assign w_a = g_lvl[gi-1].g_node[2*gj].r_sum;
               assign w_b = g_lvl[gi-1].g_node[2*gj+1].r_sum;
            end
            always_ff @(posedge clk) begin
               r_sum <= BIT_WIDTH'(sat_add(64'(signed'(w_a)), 64'(signed'(w_b)), BIT_WIDTH));
            end
         end
      end
   endgenerate

   assign o_sum = g_lvl[LVLS-1].g_node[0].r_sum;

endmodule

// File: rtl/nfu_2_accumulate.sv
// NFU stage 2: per-neuron adder trees feeding a saturating accumulator that
// sums beats into groups delimited by first/last and flags protocol errors.
module nfu_2_accumulate #(
   parameter int BIT_WIDTH = nfu_pkg::BIT_WIDTH,
   parameter int Q         = nfu_pkg::Q,
   parameter int Tn        = nfu_pkg::Tn
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   input  logic                         i_first,
   input  logic                         i_last,
   input  logic                         i_psum_en,
   input  logic [Tn*BIT_WIDTH-1:0]      i_psum,
   input  logic [Tn*Tn*BIT_WIDTH-1:0]   i_nfu1_out,
   output logic                         o_valid,
   output logic [Tn*BIT_WIDTH-1:0]      o_nfu2_out,
   output logic                         o_seq_err
);
   import nfu_pkg::*;

   localparam int LVLS = $clog2(Tn);
   localparam int LW   = Tn * BIT_WIDTH;

   generate
      if (Q >= BIT_WIDTH || Tn < 2 || (Tn & (Tn - 1)) != 0) begin : g_bad_param
         $error("nfu_2_accumulate: need Q < BIT_WIDTH and Tn a power of two >= 2");
      end
   endgenerate

   logic [BIT_WIDTH-1:0] w_tree_sum [Tn];

   genvar gi;
   generate
      for (gi = 0; gi < Tn; gi++) begin : g_tree
         nfu2_adder_tree #(
            .BIT_WIDTH (BIT_WIDTH),
            .Tn        (Tn)
         ) u_tree (
            .clk    (clk),
            .i_data (i_nfu1_out[gi*LW +: LW]),
            .o_sum  (w_tree_sum[gi])
         );
      end
   endgenerate

   // Sidebands travel with their beat so they meet the tree sum at the accumulator.
   logic [LVLS-1:0] r_vld_pipe;
   logic [LVLS-1:0] r_first_pipe;
   logic [LVLS-1:0] r_last_pipe;
   logic [LVLS-1:0] r_pen_pipe;
   logic [LW-1:0]   r_psum_pipe [LVLS];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe <= '0;
      end else begin
         r_vld_pipe[0] <= i_valid;
         for (int k = 1; k < LVLS; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
      end
   end

   always_ff @(posedge clk) begin
      r_first_pipe[0] <= i_first;
      r_last_pipe[0]  <= i_last;
      r_pen_pipe[0]   <= i_psum_en;
      r_psum_pipe[0]  <= i_psum;
      for (int k = 1; k < LVLS; k++) begin
         r_first_pipe[k] <= r_first_pipe[k-1];
         r_last_pipe[k]  <= r_last_pipe[k-1];
         r_pen_pipe[k]   <= r_pen_pipe[k-1];
         r_psum_pipe[k]  <= r_psum_pipe[k-1];
      end
   end

   logic w_beat, w_first, w_last, w_seed_psum;
   assign w_beat      = r_vld_pipe[LVLS-1];
   assign w_first     = r_first_pipe[LVLS-1];
   assign w_last      = r_last_pipe[LVLS-1];
   assign w_seed_psum = w_first & r_pen_pipe[LVLS-1];

   acc_state_e r_state, w_state_next;
   logic       w_seq_err;
   logic       w_fresh;

   // A beat with no open group is treated as a group start with zero seed.
   always_comb begin
      w_state_next = r_state;
      w_seq_err    = 1'b0;
      w_fresh      = 1'b0;
      if (w_beat) begin
         case (r_state)
            ST_IDLE: begin
               w_fresh      = 1'b1;
               w_seq_err    = ~w_first;
               w_state_next = w_last ? ST_IDLE : ST_ACCUM;
            end
            ST_ACCUM: begin
               w_fresh      = w_first;
               w_seq_err    = w_first;
               w_state_next = w_last ? ST_IDLE : ST_ACCUM;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   logic [BIT_WIDTH-1:0] r_acc      [Tn];
   logic [BIT_WIDTH-1:0] w_acc_next [Tn];

   generate
      for (gi = 0; gi < Tn; gi++) begin : g_lane
         logic [BIT_WIDTH-1:0] w_seed;
         logic [BIT_WIDTH-1:0] w_base;
         assign w_seed = w_seed_psum ? r_psum_pipe[LVLS-1][gi*BIT_WIDTH +: BIT_WIDTH] : '0;
         assign w_base = w_fresh ? w_seed : r_acc[gi];
         assign w_acc_next[gi] = BIT_WIDTH'(sat_add(64'(signed'(w_base)),
                                                    64'(signed'(w_tree_sum[gi])), BIT_WIDTH));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         o_valid    <= 1'b0;
         o_seq_err  <= 1'b0;
         o_nfu2_out <= '0;
         for (int n = 0; n < Tn; n++) r_acc[n] <= '0;
      end else begin
         r_state   <= w_state_next;
         o_valid   <= w_beat & w_last;
         o_seq_err <= w_seq_err;
         for (int n = 0; n < Tn; n++) begin
            if (w_beat) r_acc[n] <= w_acc_next[n];
            if (w_beat && w_last) o_nfu2_out[n*BIT_WIDTH +: BIT_WIDTH] <= w_acc_next[n];
         end
      end
   end

endmodule

// File: tb/tb_nfu_2_accumulate.sv
// Directed and random beats checked cycle by cycle against a group-level
// reference model of the accumulator.
module tb_nfu_2_accumulate;
   localparam int BW   = 16;
   localparam int TN   = 16;
   localparam int LW   = TN * BW;
   localparam int PW   = TN * TN * BW;
   localparam int LAT  = 4;     // beat sampled at edge k shows at outputs after edge k+LAT
   localparam int MAXC = 1200;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid, i_first, i_last, i_psum_en;
   logic [LW-1:0] i_psum;
   logic [PW-1:0] i_nfu1_out;
   logic          o_valid;
   logic [LW-1:0] o_nfu2_out;
   logic          o_seq_err;

   always #5 clk = ~clk;

   nfu_2_accumulate #(.BIT_WIDTH(BW), .Q(10), .Tn(TN)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_first    (i_first),
      .i_last     (i_last),
      .i_psum_en  (i_psum_en),
      .i_psum     (i_psum),
      .i_nfu1_out (i_nfu1_out),
      .o_valid    (o_valid),
      .o_nfu2_out (o_nfu2_out),
      .o_seq_err  (o_seq_err)
   );

   typedef struct {
      bit            rst;
      bit            vld;
      bit            first;
      bit            last;
      bit            pen;
      logic [LW-1:0] psum;
      logic [PW-1:0] prod;
   } beat_t;

   beat_t         sched[$];
   bit            exp_vld [MAXC];
   bit            exp_err [MAXC];
   bit            rst_at  [MAXC];
   logic [LW-1:0] exp_dat [MAXC];
   int            n_tests = 0;
   int            n_fail  = 0;
   bit            m_in_grp;
   int            m_acc [TN];

   task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic int sat(input int a, input int b);
      longint s;
      longint hi;
      hi = (64'sd1 <<< (BW - 1)) - 1;
      s  = longint'(a) + longint'(b);
      if (s > hi) return int'(hi);
      if (s < -hi - 1) return int'(-hi - 1);
      return int'(s);
   endfunction

   // Pairwise reduction of one neuron's products, adjacent pairs per level.
   function automatic int tree(input logic [PW-1:0] prod, input int n);
      int v[$];
      int nx[$];
      for (int s = 0; s < TN; s++) v.push_back(int'($signed(prod[(n*TN+s)*BW +: BW])));
      while (v.size() > 1) begin
         nx.delete();
         for (int i = 0; i < v.size(); i += 2) nx.push_back(sat(v[i], v[i+1]));
         v = nx;
      end
      return v[0];
   endfunction

   function automatic logic [PW-1:0] fill_prod(input logic [BW-1:0] val);
      logic [PW-1:0] r;
      for (int i = 0; i < TN*TN; i++) r[i*BW +: BW] = val;
      return r;
   endfunction

   function automatic logic [LW-1:0] fill_lane(input logic [BW-1:0] val);
      logic [LW-1:0] r;
      for (int i = 0; i < TN; i++) r[i*BW +: BW] = val;
      return r;
   endfunction

   task automatic push(input bit r, input bit v, input bit f, input bit l, input bit p,
                       input logic [LW-1:0] ps, input logic [PW-1:0] pr);
      beat_t b;
      b.rst = r; b.vld = v; b.first = f; b.last = l; b.pen = p; b.psum = ps; b.prod = pr;
      sched.push_back(b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(0, 0, 0, 0, 0, '0, '0);
   endtask

   task automatic model(input int k, input beat_t b);
      bit fresh;
      int seed;
      int base;
      logic [LW-1:0] d;
      if (b.rst) begin
         m_in_grp = 0;
         for (int n = 0; n < TN; n++) m_acc[n] = 0;
         for (int w = k; w <= k + LAT; w++) begin
            exp_vld[w] = 0;
            exp_err[w] = 0;
         end
         rst_at[k] = 1;
      end else if (b.vld) begin
         fresh = b.first || !m_in_grp;
         exp_err[k+LAT] = m_in_grp ? b.first : !b.first;
         for (int n = 0; n < TN; n++) begin
            seed = (b.first && b.pen) ? int'($signed(b.psum[n*BW +: BW])) : 0;
            base = fresh ? seed : m_acc[n];
            m_acc[n] = sat(base, tree(b.prod, n));
            d[n*BW +: BW] = BW'(m_acc[n]);
         end
         m_in_grp = !b.last;
         if (b.last) begin
            exp_vld[k+LAT] = 1;
            exp_dat[k+LAT] = d;
         end
      end
   endtask

   initial begin
      logic [LW-1:0] exp_hold;
      logic [PW-1:0] pr;
      int            mode;

      // Reset and directed scenarios.
      push(1, 0, 0, 0, 0, '0, '0); push(1, 0, 0, 0, 0, '0, '0); push(1, 0, 0, 0, 0, '0, '0);
      idle(2);
      push(0, 1, 1, 1, 0, '0, fill_prod(16'h0040)); idle(6);                 // lanes 0x0400
      push(0, 1, 1, 0, 0, '0, fill_prod(16'h0040)); idle(1);
      push(0, 1, 0, 0, 0, '0, fill_prod(16'h0040));
      push(0, 1, 0, 1, 0, '0, fill_prod(16'h0040)); idle(6);                 // lanes 0x0C00
      push(0, 1, 1, 1, 0, '0, fill_prod(16'h7000)); idle(6);                 // lanes 0x7FFF
      push(0, 1, 1, 1, 0, '0, fill_prod(16'h8000)); idle(6);                 // lanes 0x8000
      push(0, 1, 1, 1, 1, fill_lane(16'hFC00), fill_prod(16'h0040)); idle(6); // lanes 0x0000
      push(0, 1, 1, 0, 0, '0, fill_prod(16'h0040)); idle(1);
      push(1, 0, 0, 0, 0, '0, '0);
      push(0, 1, 1, 1, 0, '0, fill_prod(16'h0080)); idle(6);                 // lanes 0x0800
      push(0, 1, 0, 1, 0, '0, fill_prod(16'h0040)); idle(6);                 // seq_err, 0x0400
      push(0, 1, 1, 0, 0, '0, fill_prod(16'h0010));
      push(0, 1, 1, 1, 1, fill_lane(16'h0100), fill_prod(16'h0020)); idle(6);  // restart in group
      push(0, 1, 1, 1, 0, '0, fill_prod(16'h0001));
      push(0, 1, 1, 0, 0, '0, fill_prod(16'h0002));
      push(0, 1, 0, 1, 0, '0, fill_prod(16'h0003));
      push(0, 1, 1, 1, 0, '0, fill_prod(16'h0004)); idle(6);                 // back-to-back groups

      // Random traffic, including protocol errors and occasional resets.
      for (int c = 0; c < 600; c++) begin
         mode = $urandom_range(0, 2);
         for (int i = 0; i < TN*TN; i++) begin
            if (mode == 0)      pr[i*BW +: BW] = BW'($urandom_range(0, 511) - 256);
            else if (mode == 1) pr[i*BW +: BW] = BW'($urandom);
            else                pr[i*BW +: BW] = BW'($urandom_range(0, 4095) + 16'h0800);
         end
         push(($urandom % 100) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
              ($urandom % 3) == 0, ($urandom % 2) == 1,
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              pr);
      end
      idle(8);

      rst = 1'b0; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
      i_psum_en = 1'b0; i_psum = '0; i_nfu1_out = '0;
      exp_hold = '0;

      for (int k = 0; k < sched.size(); k++) begin
         rst        = sched[k].rst;
         i_valid    = sched[k].vld;
         i_first    = sched[k].first;
         i_last     = sched[k].last;
         i_psum_en  = sched[k].pen;
         i_psum     = sched[k].psum;
         i_nfu1_out = sched[k].prod;
         model(k, sched[k]);
         @(posedge clk);
         @(negedge clk);
         if (rst_at[k]) exp_hold = '0;
         if (exp_vld[k]) begin
            exp_hold = exp_dat[k];
            $display("[TB] cycle %0d group out lane0=%h lane15=%h err=%0d", k,
                     exp_dat[k][0 +: BW], exp_dat[k][15*BW +: BW], exp_err[k]);
         end
         check_eq($sformatf("o_valid@%0d", k), LW'(o_valid), LW'(exp_vld[k]));
         check_eq($sformatf("o_seq_err@%0d", k), LW'(o_seq_err), LW'(exp_err[k]));
         check_eq($sformatf("o_nfu2_out@%0d", k), o_nfu2_out, exp_hold);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
